// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt/ERET sequencer: state
// encoding, Cause.ExcCode values and the default handler vector.
package exc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAP   = 2'd1,
    S_VECTOR = 2'd2,
    S_ERET   = 2'd3
  } state_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VECTOR_PC_DEFAULT = 32'h0000_4180;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Signal bundle between the M stage / CP0 / PC mux and the trap sequencer.
interface exc_sequencer_if;

  // Pipeline and CP0 status towards the sequencer
  logic [4:0]  Exception;
  logic [5:0]  HWInt;
  logic [5:0]  SR_IM;
  logic        SR_IE;
  logic        SR_EXL;
  logic        M_Valid;
  logic        Is_Eret;
  logic        Branch_Delay;
  logic [31:0] PC_M;
  logic [31:0] EPC_Q;

  // Sequencer controls back to the pipeline and CP0
  logic        Flush;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        EPC_WE;
  logic [31:0] EPC_D;
  logic        Cause_WE;
  logic [4:0]  Exc_Code;
  logic        BD;
  logic [5:0]  IP;
  logic        Set_EXL;
  logic        Clear_EXL;
  logic        Busy;

  modport master (
    output Exception, HWInt, SR_IM, SR_IE, SR_EXL, M_Valid, Is_Eret,
           Branch_Delay, PC_M, EPC_Q,
    input  Flush, Stall, Redirect, Redirect_PC, EPC_WE, EPC_D, Cause_WE,
           Exc_Code, BD, IP, Set_EXL, Clear_EXL, Busy
  );

  modport slave (
    input  Exception, HWInt, SR_IM, SR_IE, SR_EXL, M_Valid, Is_Eret,
           Branch_Delay, PC_M, EPC_Q,
    output Flush, Stall, Redirect, Redirect_PC, EPC_WE, EPC_D, Cause_WE,
           Exc_Code, BD, IP, Set_EXL, Clear_EXL, Busy
  );

endinterface

// File: rtl/exc_prio_enc.sv
// Trap priority encoder: interrupt first, then exception bits [0]..[4],
// producing the Cause.ExcCode and a single take flag.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [4:0] exception_i,
  input  logic       int_take_i,
  output logic [4:0] code_o,
  output logic       take_o
);

  always_comb begin
    // NOTE: every output gets a default before the priority chain so no
    // path leaves it unassigned and no latch is inferred.
    code_o = EXC_INT;
    take_o = int_take_i | (|exception_i);
    if (int_take_i)          code_o = EXC_INT;
    else if (exception_i[0]) code_o = EXC_ADEL;
    else if (exception_i[1]) code_o = EXC_RI;
    else if (exception_i[2]) code_o = EXC_OV;
    else if (exception_i[3]) code_o = EXC_ADES;
    else if (exception_i[4]) code_o = EXC_ADEL;
  end

endmodule

// File: rtl/exc_sequencer.sv
// Multi-cycle trap/ERET sequencer: detects in IDLE, writes CP0 in TRAP,
// redirects to the handler in VECTOR or back to EPC in ERET.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_PC = VECTOR_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  exc_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] pc_q, pc_d;
  logic [5:0]  ip_q, ip_d;
  logic        skip_epc_q, skip_epc_d;

  logic        int_take;
  logic        eret_take;
  logic        trap_take;
  logic [4:0]  trap_code;

  assign int_take = bus.M_Valid & bus.SR_IE & ~bus.SR_EXL & (|(bus.HWInt & bus.SR_IM));

  exc_prio_enc u_prio_enc (
    .exception_i (bus.Exception & {5{bus.M_Valid}}),
    .int_take_i  (int_take),
    .code_o      (trap_code),
    .take_o      (trap_take)
  );

  assign eret_take = bus.M_Valid & bus.Is_Eret & ~trap_take;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      bd_q       <= 1'b0;
      pc_q       <= '0;
      ip_q       <= '0;
      skip_epc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      bd_q       <= bd_d;
      pc_q       <= pc_d;
      ip_q       <= ip_d;
      skip_epc_q <= skip_epc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    code_d          = code_q;
    bd_d            = bd_q;
    pc_d            = pc_q;
    ip_d            = ip_q;
    skip_epc_d      = skip_epc_q;
    bus.Flush       = 1'b0;
    bus.Stall       = 1'b0;
    bus.Redirect    = 1'b0;
    bus.Redirect_PC = '0;
    bus.EPC_WE      = 1'b0;
    bus.EPC_D       = '0;
    bus.Cause_WE    = 1'b0;
    bus.Exc_Code    = '0;
    bus.BD          = 1'b0;
    bus.IP          = '0;
    bus.Set_EXL     = 1'b0;
    bus.Clear_EXL   = 1'b0;
    bus.Busy        = (state_q != S_IDLE);

    // A reset cycle suppresses every side effect, even mid-sequence.
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (trap_take) begin
            bus.Flush  = 1'b1;
            code_d     = trap_code;
            bd_d       = bus.Branch_Delay;
            pc_d       = bus.PC_M;
            ip_d       = bus.HWInt;
            skip_epc_d = bus.SR_EXL;
            state_d    = S_TRAP;
          end else if (eret_take) begin
            bus.Flush = 1'b1;
            state_d   = S_ERET;
          end
        end
        S_TRAP: begin
          bus.Cause_WE = 1'b1;
          bus.Exc_Code = code_q;
          bus.IP       = ip_q;
          bus.BD       = bd_q & ~skip_epc_q;
          bus.EPC_WE   = ~skip_epc_q;
          bus.EPC_D    = epc_value(pc_q, bd_q);
          bus.Set_EXL  = 1'b1;
          bus.Flush    = 1'b1;
          bus.Stall    = 1'b1;
          state_d      = S_VECTOR;
        end
        S_VECTOR: begin
          bus.Redirect    = 1'b1;
          bus.Redirect_PC = VECTOR_PC;
          bus.Flush       = 1'b1;
          state_d         = S_IDLE;
        end
        S_ERET: begin
          bus.Clear_EXL   = 1'b1;
          bus.Redirect    = 1'b1;
          bus.Redirect_PC = bus.EPC_Q;
          bus.Flush       = 1'b1;
          state_d         = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: table of single-instruction scenarios
// plus hand-written sequences for masking of M_Valid and mid-trap reset.
module tb_exc_sequencer;
  import exc_pkg::*;

  typedef enum logic [1:0] {K_NONE, K_TRAP, K_ERET} kind_e;

  typedef struct {
    logic [4:0]  exc;
    logic [5:0]  hwint;
    logic [5:0]  im;
    logic        ie;
    logic        exl;
    logic        mv;
    logic        eret;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] epc_q;
    kind_e       kind;
    logic [4:0]  code;
    logic [5:0]  ip;
    logic        bd_o;
    logic        epc_we;
    logic [31:0] epc_d;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exc_sequencer_if bus ();

  exc_sequencer #(.VECTOR_PC(32'h0000_4180)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.Exception    = 5'b0;
    bus.HWInt        = 6'b0;
    bus.SR_IM        = 6'b0;
    bus.SR_IE        = 1'b0;
    bus.SR_EXL       = 1'b0;
    bus.M_Valid      = 1'b0;
    bus.Is_Eret      = 1'b0;
    bus.Branch_Delay = 1'b0;
    bus.PC_M         = 32'h0;
    bus.EPC_Q        = 32'h0;
  endtask

  function automatic vec_t mk(
    input logic [4:0] exc, input logic [5:0] hw, input logic [5:0] im,
    input logic ie, input logic exl, input logic mv, input logic er, input logic bd,
    input logic [31:0] pc, input logic [31:0] epc_q, input kind_e k,
    input logic [4:0] code, input logic [5:0] ip, input logic bo, input logic we,
    input logic [31:0] ed);
    vec_t v;
    v.exc = exc; v.hwint = hw; v.im = im; v.ie = ie; v.exl = exl; v.mv = mv;
    v.eret = er; v.bd = bd; v.pc = pc; v.epc_q = epc_q; v.kind = k;
    v.code = code; v.ip = ip; v.bd_o = bo; v.epc_we = we; v.epc_d = ed;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    step();
    bus.Exception = v.exc;   bus.HWInt   = v.hwint; bus.SR_IM  = v.im;
    bus.SR_IE     = v.ie;    bus.SR_EXL  = v.exl;   bus.M_Valid = v.mv;
    bus.Is_Eret   = v.eret;  bus.Branch_Delay = v.bd;
    bus.PC_M      = v.pc;    bus.EPC_Q   = v.epc_q;
    @(negedge clk);
    check({p, "_T_flush"},    32'(bus.Flush),    32'(v.kind != K_NONE));
    check({p, "_T_busy"},     32'(bus.Busy),     32'(1'b0));
    check({p, "_T_cause_we"}, 32'(bus.Cause_WE), 32'(1'b0));
    // Deasserted sources after detection must not change the captured trap
    step();
    bus.M_Valid = 1'b0;
    bus.HWInt   = 6'b0;
    @(negedge clk);
    case (v.kind)
      K_TRAP: begin
        check({p, "_T1_cause_we"}, 32'(bus.Cause_WE), 32'(1'b1));
        check({p, "_T1_code"},     32'(bus.Exc_Code), 32'(v.code));
        check({p, "_T1_ip"},       32'(bus.IP),       32'(v.ip));
        check({p, "_T1_bd"},       32'(bus.BD),       32'(v.bd_o));
        check({p, "_T1_epc_we"},   32'(bus.EPC_WE),   32'(v.epc_we));
        check({p, "_T1_epc_d"},    bus.EPC_D,         v.epc_d);
        check({p, "_T1_set_exl"},  32'(bus.Set_EXL),  32'(1'b1));
        check({p, "_T1_stall"},    32'(bus.Stall),    32'(1'b1));
        check({p, "_T1_flush"},    32'(bus.Flush),    32'(1'b1));
        check({p, "_T1_redirect"}, 32'(bus.Redirect), 32'(1'b0));
        step();
        @(negedge clk);
        check({p, "_T2_redirect"}, 32'(bus.Redirect), 32'(1'b1));
        check({p, "_T2_rpc"},      bus.Redirect_PC,   32'h0000_4180);
        check({p, "_T2_flush"},    32'(bus.Flush),    32'(1'b1));
        check({p, "_T2_cause_we"}, 32'(bus.Cause_WE), 32'(1'b0));
        check({p, "_T2_busy"},     32'(bus.Busy),     32'(1'b1));
        step();
        @(negedge clk);
        check({p, "_T3_busy"},     32'(bus.Busy),     32'(1'b0));
        check({p, "_T3_redirect"}, 32'(bus.Redirect), 32'(1'b0));
      end
      K_ERET: begin
        check({p, "_T1_clear_exl"}, 32'(bus.Clear_EXL), 32'(1'b1));
        check({p, "_T1_redirect"},  32'(bus.Redirect),  32'(1'b1));
        check({p, "_T1_rpc"},       bus.Redirect_PC,    v.epc_q);
        check({p, "_T1_flush"},     32'(bus.Flush),     32'(1'b1));
        check({p, "_T1_cause_we"},  32'(bus.Cause_WE),  32'(1'b0));
        check({p, "_T1_set_exl"},   32'(bus.Set_EXL),   32'(1'b0));
        step();
        @(negedge clk);
        check({p, "_T2_busy"},      32'(bus.Busy),      32'(1'b0));
        check({p, "_T2_redirect"},  32'(bus.Redirect),  32'(1'b0));
      end
      default: begin
        check({p, "_T1_busy"},  32'(bus.Busy),  32'(1'b0));
        check({p, "_T1_flush"}, 32'(bus.Flush), 32'(1'b0));
      end
    endcase
    quiet();
  endtask

  vec_t vecs[16];

  initial begin
    //             exc       hwint      im         ie    exl   mv    eret  bd    pc             epc_q          kind    code   ip         bd_o  we    epc_d
    vecs[0]  = mk(5'b00100, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h0,         K_TRAP, 5'd12, 6'b000000, 1'b0, 1'b1, 32'h0000_3010);
    vecs[1]  = mk(5'b01010, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3020, 32'h0,         K_TRAP, 5'd10, 6'b000000, 1'b1, 1'b1, 32'h0000_301C);
    vecs[2]  = mk(5'b00100, 6'b000001, 6'b000001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3030, 32'h0,         K_TRAP, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_3030);
    vecs[3]  = mk(5'b00100, 6'b000001, 6'b000001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3040, 32'h0,         K_TRAP, 5'd12, 6'b000001, 1'b0, 1'b0, 32'h0000_303C);
    vecs[4]  = mk(5'b00000, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3048, 32'h0000_3044, K_ERET, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[5]  = mk(5'b00010, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3050, 32'h0000_3044, K_TRAP, 5'd10, 6'b000000, 1'b0, 1'b1, 32'h0000_3050);
    vecs[6]  = mk(5'b00000, 6'b000001, 6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3058, 32'h0,         K_NONE, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[7]  = mk(5'b10000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3060, 32'h0,         K_TRAP, 5'd4,  6'b000000, 1'b0, 1'b1, 32'h0000_3060);
    vecs[8]  = mk(5'b11111, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3070, 32'h0,         K_TRAP, 5'd4,  6'b000000, 1'b0, 1'b1, 32'h0000_3070);
    vecs[9]  = mk(5'b01000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         K_TRAP, 5'd5,  6'b000000, 1'b1, 1'b1, 32'hFFFF_FFFC);
    vecs[10] = mk(5'b00000, 6'b100000, 6'b011111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3078, 32'h0,         K_NONE, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[11] = mk(5'b00000, 6'b000001, 6'b000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_307C, 32'h0,         K_NONE, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[12] = mk(5'b00000, 6'b100000, 6'b100000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3080, 32'h0,         K_TRAP, 5'd0,  6'b100000, 1'b0, 1'b1, 32'h0000_3080);
    vecs[13] = mk(5'b00100, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3084, 32'h0,         K_NONE, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[14] = mk(5'b00000, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3088, 32'h0000_3044, K_NONE, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0);
    vecs[15] = mk(5'b00000, 6'b000010, 6'b000010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3090, 32'h0000_3044, K_TRAP, 5'd0,  6'b000010, 1'b0, 1'b1, 32'h0000_3090);

    quiet();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",     32'(bus.Busy),     32'(1'b0));
    check("rst_flush",    32'(bus.Flush),    32'(1'b0));
    check("rst_redirect", 32'(bus.Redirect), 32'(1'b0));
    check("rst_rpc",      bus.Redirect_PC,   32'h0);
    check("rst_epc_d",    bus.EPC_D,         32'h0);
    check("rst_code",     32'(bus.Exc_Code), 32'h0);
    check("rst_cause_we", 32'(bus.Cause_WE), 32'(1'b0));

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Pending enabled interrupt is held off by a bubble, then taken
    step();
    bus.HWInt = 6'b000100; bus.SR_IM = 6'b111111; bus.SR_IE = 1'b1;
    bus.M_Valid = 1'b0; bus.PC_M = 32'h0000_30A0;
    @(negedge clk);
    check("mv0_flush", 32'(bus.Flush), 32'(1'b0));
    step();
    bus.M_Valid = 1'b1;
    @(negedge clk);
    check("mv1_flush", 32'(bus.Flush), 32'(1'b1));
    step();
    bus.M_Valid = 1'b0; bus.HWInt = 6'b0;
    @(negedge clk);
    check("mv1_cause_we", 32'(bus.Cause_WE), 32'(1'b1));
    check("mv1_code",     32'(bus.Exc_Code), 32'(5'd0));
    check("mv1_ip",       32'(bus.IP),       32'(6'b000100));
    check("mv1_epc_d",    bus.EPC_D,         32'h0000_30A0);
    step();
    step();
    quiet();

    // Reset while in TRAP cancels the sequence without side effects
    step();
    bus.Exception = 5'b00001; bus.M_Valid = 1'b1; bus.PC_M = 32'h0000_30B0;
    @(negedge clk);
    check("rtrap_T_flush", 32'(bus.Flush), 32'(1'b1));
    step();
    quiet();
    reset = 1'b1;
    @(negedge clk);
    check("rtrap_cause_we", 32'(bus.Cause_WE), 32'(1'b0));
    check("rtrap_epc_we",   32'(bus.EPC_WE),   32'(1'b0));
    check("rtrap_set_exl",  32'(bus.Set_EXL),  32'(1'b0));
    check("rtrap_redirect", 32'(bus.Redirect), 32'(1'b0));
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rtrap_n1_busy",     32'(bus.Busy),     32'(1'b0));
    check("rtrap_n1_redirect", 32'(bus.Redirect), 32'(1'b0));
    check("rtrap_n1_flush",    32'(bus.Flush),    32'(1'b0));
    check("rtrap_n1_rpc",      bus.Redirect_PC,   32'h0);
    step();
    @(negedge clk);
    check("rtrap_n2_busy",     32'(bus.Busy),     32'(1'b0));
    check("rtrap_n2_redirect", 32'(bus.Redirect), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Multi-cycle exception/interrupt/ERET sequencer for the 5-stage MIPS pipeline. Samples M-stage exception flags, hardware interrupts and `eret`, then drives CP0 writes (EPC, Cause, EXL), pipeline flush/stall and the PC redirect to the handler vector or back to EPC. It sits between the M stage, the CP0 register file and the F-stage PC mux, and owns the "take trap" decision.

## Interface
- `VECTOR_PC`, 32'h0000_4180: handler entry address.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Exception` in 5: M-stage flags. [0] fetch AdEL, [1] RI, [2] Ov, [3] AdES, [4] load AdEL.
- `HWInt` in 6: external interrupt lines [7:2], level-sensitive.
- `SR_IM` in 6, `SR_IE` in 1, `SR_EXL` in 1: current CP0 Status fields.
- `M_Valid` in 1: M stage holds a real instruction, not a bubble.
- `Is_Eret` in 1: M-stage instruction is `eret`.
- `Branch_Delay` in 1: M-stage instruction is in a delay slot.
- `PC_M` in 32: M-stage PC. `EPC_Q` in 32: current EPC contents.
- `Flush` out 1: squash F/D/E/M contents; M instruction must not reach W.
- `Stall` out 1: freeze PC and pipeline registers.
- `Redirect` out 1, `Redirect_PC` out 32: PC-mux override.
- `EPC_WE` out 1, `EPC_D` out 32.
- `Cause_WE` out 1, `Exc_Code` out 5 (Cause[6:2]), `BD` out 1, `IP` out 6.
- `Set_EXL` out 1, `Clear_EXL` out 1, `Busy` out 1.

## Operation
- States: IDLE, TRAP, VECTOR, ERET.
- `int_take` = M_Valid & SR_IE & !SR_EXL & |(HWInt & SR_IM). `exc_take` = M_Valid & |Exception. `eret_take` = M_Valid & Is_Eret & !exc_take & !int_take.
- Priority: interrupt > exception > eret. Among exception bits, [0] highest ... [4] lowest; codes [0]->4, [1]->10, [2]->12, [3]->5, [4]->4; interrupt -> 0.
- IDLE: on int_take|exc_take, Flush=1 combinationally this cycle; capture code, BD, EPC value, HWInt into registers; set `skip_epc`=SR_EXL; -> TRAP. On eret_take: Flush=1, -> ERET. Otherwise all outputs 0.
- TRAP (1 cycle): Cause_WE=1 with captured Exc_Code/IP; BD = captured BD unless skip_epc; EPC_WE = !skip_epc; EPC_D = captured BD ? PC-4 : PC (32-bit wrap, no alignment masking); Set_EXL=1; Flush=1; Stall=1. -> VECTOR.
- VECTOR (1 cycle): Redirect=1, Redirect_PC=VECTOR_PC, Flush=1. -> IDLE.
- ERET (1 cycle): Clear_EXL=1, Redirect=1, Redirect_PC=EPC_Q (sampled this cycle), Flush=1. -> IDLE.
- Inputs ignored outside IDLE; a trap cannot be re-entered until IDLE.
- Exception with SR_EXL=1: vectors normally, EPC and BD not updated.
- Busy = state != IDLE.

## Timing
- Reset: state IDLE; all registered outputs 0; Redirect_PC = 0, EPC_D = 0, Exc_Code = 0.
- Trap latency: detect cycle T (Flush), T+1 CP0 writes, T+2 redirect, first handler fetch at T+3.
- ERET latency: detect cycle T (Flush), T+1 redirect + Clear_EXL, EPC-target fetch at T+2.
- Reset asserted in TRAP/VECTOR/ERET: next edge IDLE, no CP0 write, redirect or EXL change that cycle or later.
- Interrupt deasserting after detection has no effect; captured IP is used.
- M_Valid=0 blocks all takes, including pending interrupts.

## Structure
- Shared package `exc_pkg`: state encoding, ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12), VECTOR_PC default.
- One sub-module `exc_prio_enc`: combinational Exception[4:0] + int_take -> 5-bit code and take flag.
- Outputs other than detect-cycle Flush are driven from registered state/captures.

## Test plan
- Exception=5'b00100, PC_M=0x3010, BD=0, EXL=0 -> T: Flush; T+1: EPC_D=0x3010, Exc_Code=12, Set_EXL; T+2: Redirect_PC=0x4180.
- Exception=5'b01010, BD=1, PC_M=0x3020 -> Exc_Code=10 (bit1 wins), EPC_D=0x301C, BD=1.
- HWInt[2]=1, IM[2]=1, IE=1, Exception[2]=1 same cycle -> Exc_Code=0, IP=6'b000001; with SR_EXL=1 instead -> Exc_Code=12, EPC_WE=0.
- Is_Eret=1, EPC_Q=0x3044 -> T: Flush; T+1: Clear_EXL, Redirect_PC=0x3044; Is_Eret with Exception[1] -> trap with code 10.
- reset asserted during TRAP -> next cycle all outputs 0, state IDLE, no Redirect.
- M_Valid=0 with pending enabled interrupt -> no take; M_Valid=1 next cycle -> take.
